// File: rtl/game_pkg.sv
// Shared types and helpers for the game sequencer: state encoding, widths
// and the frames-per-tick rule used by the tick divider.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    WAIT   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4,
    WON    = 3'd5
  } game_state_t;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;  // o_level width of the default eight-level build

  // Signed int arithmetic so a large level can never wrap below the floor.
  function automatic int frames_for_level(input int level, input int base_frames,
                                          input int step_frames, input int min_frames);
    int frames;
    frames = base_frames - level * step_frames;
    return (frames < min_frames) ? min_frames : frames;
  endfunction

endpackage

// File: rtl/game_ctrl_tick_divider.sv
// Vsync rising-edge detector and level-dependent frame counter; emits a
// one-cycle due pulse every frames_for_level(level) vsyncs while enabled.
module tick_divider
  import game_pkg::*;
#(
  parameter int BASE_FRAMES = 30,
  parameter int STEP_FRAMES = 3,
  parameter int MIN_FRAMES  = 4,
  parameter int LW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vsync,
  input  logic          run_enable,
  input  logic          clear,
  input  logic [LW-1:0] level,
  output logic          due
);

  localparam int MAX_P = (BASE_FRAMES > MIN_FRAMES) ? BASE_FRAMES : MIN_FRAMES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  logic             vsync_q;
  logic             rise;
  logic             due_q, due_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    rise     = i_vsync & ~vsync_q;
    last_cnt = CNT_W'(frames_for_level(int'(level), BASE_FRAMES, STEP_FRAMES, MIN_FRAMES) - 1);
    cnt_d    = cnt_q;
    due_d    = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run_enable && rise) begin
      // >= rather than == so a level raised mid-period cannot skip the wrap.
      if (cnt_q >= last_cnt) begin
        cnt_d = '0;
        due_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments only; the _d logic above is blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      due_q   <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      cnt_q   <= cnt_d;
      due_q   <= due_d;
    end
  end

  assign due = due_q;

endmodule

// File: rtl/game_ctrl.sv
// Multi-player game sequencer: tick/done handshake, pause, lives, scores,
// automatic speed-up and sticky game outcome.
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS      = 1,
  parameter int LIVES            = 3,
  parameter int SCORE_W          = 8,
  parameter int LEVELS           = 8,
  parameter int BASE_FRAMES      = 30,
  parameter int STEP_FRAMES      = 3,
  parameter int MIN_FRAMES       = 4,
  parameter int APPLES_PER_LEVEL = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_restart,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_vsync,
  input  logic                           i_ready,
  input  logic                           i_speed_up,
  input  logic                           i_speed_down,
  input  logic [NUM_PLAYERS-1:0]         i_tick_done,
  input  logic [NUM_PLAYERS-1:0]         i_fail,
  input  logic [NUM_PLAYERS-1:0]         i_success,
  input  logic [NUM_PLAYERS-1:0]         i_eat,
  output logic [NUM_PLAYERS-1:0]         o_tick,
  output logic [NUM_PLAYERS-1:0]         o_respawn,
  output logic [NUM_PLAYERS-1:0]         o_alive,
  output logic [NUM_PLAYERS*2-1:0]       o_lives,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_score,
  output logic [$clog2(LEVELS)-1:0]      o_level,
  output logic [2:0]                     o_state,
  output logic                           o_failure,
  output logic                           o_success,
  output logic                           o_tick_missed
);

  localparam int N  = NUM_PLAYERS;
  localparam int LW = $clog2(LEVELS);
  localparam int EW = $clog2(APPLES_PER_LEVEL + N + 1);
  localparam logic [LW-1:0] TOP_LEVEL = LW'(LEVELS - 1);

  game_state_t               state_q, state_d, origin_q, origin_d;
  logic [N-1:0]              alive_q, alive_d, done_q, done_d;
  logic [N-1:0]              tick_q, tick_d, respawn_q, respawn_d;
  logic [N-1:0][LIVES_W-1:0] lives_q, lives_d;
  logic [N-1:0][SCORE_W-1:0] score_q, score_d;
  logic [LW-1:0]             level_q, level_d;
  logic [EW-1:0]             eat_cnt_q, eat_cnt_d, eat_sum;
  logic                      missed_q, missed_d, failure_q, failure_d, success_q, success_d;
  logic                      active, tick_due, level_up;
  logic [N-1:0]              fail_v, succ_v, eat_v;

  assign active = (state_q == RUN) || (state_q == WAIT);

  tick_divider #(
    .BASE_FRAMES(BASE_FRAMES),
    .STEP_FRAMES(STEP_FRAMES),
    .MIN_FRAMES (MIN_FRAMES),
    .LW         (LW)
  ) u_tick_divider (
    .clk       (clk),
    .rst       (rst),
    .i_vsync   (i_vsync),
    .run_enable(active),
    .clear     (i_restart),
    .level     (level_q),
    .due       (tick_due)
  );

  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    alive_d   = alive_q;
    done_d    = done_q;
    lives_d   = lives_q;
    score_d   = score_q;
    level_d   = level_q;
    failure_d = failure_q;
    success_d = success_q;
    tick_d    = '0;
    respawn_d = '0;
    missed_d  = 1'b0;

    // Player pulses only count while playing and from live players; fail beats success.
    fail_v  = i_fail & alive_q & {N{active}};
    succ_v  = i_success & alive_q & ~fail_v & {N{active}};
    eat_v   = i_eat & alive_q & {N{active}};
    eat_sum = eat_cnt_q;

    for (int p = 0; p < N; p++) begin
      if (fail_v[p]) begin
        if (lives_q[p] != '0) begin
          lives_d[p]   = lives_q[p] - LIVES_W'(1);
          respawn_d[p] = 1'b1;
        end else begin
          alive_d[p] = 1'b0;
        end
        if (state_q == WAIT) done_d[p] = 1'b1;
      end
      if (eat_v[p]) begin
        if (score_q[p] != '1) score_d[p] = score_q[p] + SCORE_W'(1);
        eat_sum = eat_sum + EW'(1);
      end
    end

    level_up  = i_speed_up;
    eat_cnt_d = eat_sum;
    if (eat_sum >= EW'(APPLES_PER_LEVEL)) begin
      eat_cnt_d = eat_sum - EW'(APPLES_PER_LEVEL);
      level_up  = 1'b1;
    end
    if (level_up && !i_speed_down && level_q != TOP_LEVEL) level_d = level_q + LW'(1);
    else if (i_speed_down && !level_up && level_q != '0)   level_d = level_q - LW'(1);

    case (state_q)
      IDLE: if (i_start) state_d = RUN;
      RUN: begin
        if (i_pause) begin
          state_d  = PAUSED;
          origin_d = RUN;
        end else if (tick_due && i_ready) begin
          tick_d  = alive_d;
          done_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        done_d   = done_d | (i_tick_done & alive_q);
        missed_d = tick_due;
        if (i_pause) begin
          state_d  = PAUSED;
          origin_d = WAIT;
        end else if (&(done_d | ~alive_d)) begin
          state_d = RUN;
        end
      end
      PAUSED: if (i_pause) state_d = origin_q;
      default: ;
    endcase

    if (active && alive_d == '0) begin
      state_d   = OVER;
      failure_d = 1'b1;
      tick_d    = '0;
    end
    if (|succ_v) begin
      state_d   = WON;
      success_d = 1'b1;
      tick_d    = '0;
    end

    // Restart reloads everything except the speed level.
    if (i_restart) begin
      state_d   = IDLE;
      origin_d  = RUN;
      alive_d   = '1;
      done_d    = '0;
      lives_d   = {N{LIVES_W'(LIVES)}};
      score_d   = '0;
      level_d   = level_q;
      eat_cnt_d = '0;
      failure_d = 1'b0;
      success_d = 1'b0;
      tick_d    = '0;
      respawn_d = '0;
      missed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      origin_q  <= RUN;
      alive_q   <= '1;
      done_q    <= '0;
      lives_q   <= {N{LIVES_W'(LIVES)}};
      score_q   <= '0;
      level_q   <= '0;
      eat_cnt_q <= '0;
      tick_q    <= '0;
      respawn_q <= '0;
      missed_q  <= 1'b0;
      failure_q <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      origin_q  <= origin_d;
      alive_q   <= alive_d;
      done_q    <= done_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      level_q   <= level_d;
      eat_cnt_q <= eat_cnt_d;
      tick_q    <= tick_d;
      respawn_q <= respawn_d;
      missed_q  <= missed_d;
      failure_q <= failure_d;
      success_q <= success_d;
    end
  end

  assign o_tick        = tick_q;
  assign o_respawn     = respawn_q;
  assign o_alive       = alive_q;
  assign o_lives       = lives_q;
  assign o_score       = score_q;
  assign o_level       = level_q;
  assign o_state       = state_q;
  assign o_failure     = failure_q;
  assign o_success     = success_q;
  assign o_tick_missed = missed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with two players: directed handshake,
// level, lives and scoring sequences plus a randomized run against a model.
module tb_game_ctrl;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst, i_restart, i_start, i_pause, i_vsync, i_ready, i_speed_up, i_speed_down;
  logic [N-1:0]   i_tick_done, i_fail, i_success, i_eat;
  logic [N-1:0]   o_tick, o_respawn, o_alive;
  logic [2*N-1:0] o_lives;
  logic [8*N-1:0] o_score;
  logic [2:0]     o_level, o_state;
  logic           o_failure, o_success, o_tick_missed;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  game_ctrl #(.NUM_PLAYERS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_restart    (i_restart),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_vsync      (i_vsync),
    .i_ready      (i_ready),
    .i_speed_up   (i_speed_up),
    .i_speed_down (i_speed_down),
    .i_tick_done  (i_tick_done),
    .i_fail       (i_fail),
    .i_success    (i_success),
    .i_eat        (i_eat),
    .o_tick       (o_tick),
    .o_respawn    (o_respawn),
    .o_alive      (o_alive),
    .o_lives      (o_lives),
    .o_score      (o_score),
    .o_level      (o_level),
    .o_state      (o_state),
    .o_failure    (o_failure),
    .o_success    (o_success),
    .o_tick_missed(o_tick_missed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    step();
    i_vsync = 1'b0;
    step();
  endtask

  task automatic wait_tick(output int frames);
    frames = 0;
    do begin
      vsync_pulse();
      frames++;
    end while (o_tick == '0 && frames < 64);
  endtask

  task automatic run_frames(input int n, output int ticks, output int misses, output int last_miss);
    ticks = 0; misses = 0; last_miss = -1;
    for (int i = 0; i < n; i++) begin
      vsync_pulse();
      if (o_tick != '0) ticks++;
      if (o_tick_missed) begin misses++; last_miss = i; end
    end
  endtask

  task automatic do_start();   i_start = 1'b1;   step(); i_start = 1'b0;   endtask
  task automatic do_pause();   i_pause = 1'b1;   step(); i_pause = 1'b0;   endtask
  task automatic do_restart(); i_restart = 1'b1; step(); i_restart = 1'b0; endtask
  task automatic do_up();      i_speed_up = 1'b1; step(); i_speed_up = 1'b0; endtask
  task automatic do_down();    i_speed_down = 1'b1; step(); i_speed_down = 1'b0; endtask
  task automatic do_fail(input logic [N-1:0] m) ; i_fail = m; step(); i_fail = '0; endtask
  task automatic do_eat(input logic [N-1:0] m)  ; i_eat = m;  step(); i_eat = '0;  endtask
  task automatic do_done(input logic [N-1:0] m) ; i_tick_done = m; step(); i_tick_done = '0; endtask

  typedef struct {
    logic       up;
    logic       dn;
    logic [2:0] exp_level;
  } lvl_vec_t;

  // Reference model for the randomized phase.
  int m_state, m_level, m_eats;
  int m_lives[N], m_score[N];
  bit m_alive[N], m_fail_flag, m_succ_flag;
  logic [N-1:0] m_resp;

  task automatic model_restart();
    m_state = 0; m_eats = 0; m_fail_flag = 0; m_succ_flag = 0; m_resp = '0;
    for (int p = 0; p < N; p++) begin m_lives[p] = 3; m_alive[p] = 1; m_score[p] = 0; end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    lvl_vec_t lvl_tab[$];
    int frames, ticks, misses, last_miss;

    rst = 1'b1; i_restart = 0; i_start = 0; i_pause = 0; i_vsync = 0; i_ready = 1;
    i_speed_up = 0; i_speed_down = 0; i_tick_done = '0; i_fail = '0; i_success = '0; i_eat = '0;
    step(); step();
    rst = 1'b0;

    check("reset state",   o_state, 0);
    check("reset alive",   o_alive, 2'b11);
    check("reset lives",   o_lives, 4'hF);
    check("reset score",   o_score, 0);
    check("reset level",   o_level, 0);
    check("reset outcome", {o_failure, o_success}, 0);
    check("reset pulses",  {o_tick, o_respawn, o_tick_missed}, 0);

    // Level stepping: saturation at both ends and simultaneous up/down.
    lvl_tab.push_back('{1'b0, 1'b1, 3'd0});
    lvl_tab.push_back('{1'b1, 1'b0, 3'd1});
    lvl_tab.push_back('{1'b1, 1'b1, 3'd1});
    lvl_tab.push_back('{1'b0, 1'b1, 3'd0});
    for (int i = 0; i < 10; i++) lvl_tab.push_back('{1'b1, 1'b0, 3'((i < 7) ? i + 1 : 7)});
    lvl_tab.push_back('{1'b1, 1'b1, 3'd7});
    lvl_tab.push_back('{1'b0, 1'b1, 3'd6});
    foreach (lvl_tab[i]) begin
      i_speed_up = lvl_tab[i].up; i_speed_down = lvl_tab[i].dn;
      step();
      i_speed_up = 0; i_speed_down = 0;
      check($sformatf("level vec %0d", i), o_level, lvl_tab[i].exp_level);
    end
    for (int i = 0; i < 7; i++) do_down();
    check("level floor", o_level, 0);

    // Tick handshake at level 0: 30 frames per tick.
    do_start();
    check("start -> RUN", o_state, 1);
    wait_tick(frames);
    check("first tick frames", frames, 30);
    check("first tick mask", o_tick, 2'b11);
    check("tick -> WAIT", o_state, 2);
    do_done(2'b01);
    check("partial done stays WAIT", o_state, 2);
    do_done(2'b10);
    check("all done -> RUN", o_state, 1);

    // Withheld done: the next due tick is reported missed, not issued.
    wait_tick(frames);
    check("second tick frames", frames, 30);
    run_frames(30, ticks, misses, last_miss);
    check("missed: no tick", ticks, 0);
    check("missed: one pulse", misses, 1);
    check("missed: on period end", last_miss, 29);
    check("missed: still WAIT", o_state, 2);

    // Pause from WAIT and from RUN; the frame counter must freeze.
    do_pause();
    check("pause WAIT -> PAUSED", o_state, 3);
    run_frames(50, ticks, misses, last_miss);
    check("paused: no tick/miss", ticks + misses, 0);
    do_pause();
    check("unpause -> WAIT", o_state, 2);
    do_done(2'b11);
    check("done after pause -> RUN", o_state, 1);
    run_frames(10, ticks, misses, last_miss);
    do_pause();
    check("pause RUN -> PAUSED", o_state, 3);
    run_frames(50, ticks, misses, last_miss);
    check("paused RUN: no tick", ticks, 0);
    do_pause();
    check("unpause -> RUN", o_state, 1);
    wait_tick(frames);
    check("frozen counter resumes", frames, 20);

    // Five apples across players raise the level once.
    do_eat(2'b01); do_eat(2'b10); do_eat(2'b01); do_eat(2'b10);
    check("4 eats level", o_level, 0);
    do_eat(2'b01);
    check("5 eats level", o_level, 1);
    check("scores 3/2", o_score, 16'h0203);

    do_restart();
    check("restart state", o_state, 0);
    check("restart score", o_score, 0);
    check("restart keeps level", o_level, 1);
    check("restart lives", {o_alive, o_lives}, 6'h3F);

    // Level 7: period clamps to max(4, 30-21) = 9.
    for (int i = 0; i < 8; i++) do_up();
    check("level 7 saturate", o_level, 7);
    do_start();
    wait_tick(frames);
    check("level 7 frames", frames, 9);
    do_done(2'b11);

    // Lives: three respawns, then death; all dead -> OVER.
    for (int i = 0; i < 3; i++) begin
      do_fail(2'b01);
      check($sformatf("p0 respawn %0d", i), o_respawn, 2'b01);
      check($sformatf("p0 lives %0d", i), o_lives[1:0], 2 - i);
    end
    do_fail(2'b01);
    check("p0 dies", {o_respawn, o_alive}, 4'b0010);
    do_fail(2'b01);
    check("dead p0 ignored", {o_respawn, o_alive, o_lives}, 8'b00_10_1100);
    for (int i = 0; i < 4; i++) do_fail(2'b10);
    check("all dead alive", o_alive, 0);
    check("all dead failure", o_failure, 1);
    check("all dead OVER", o_state, 4);
    do_eat(2'b10);
    do_start();
    check("OVER ignores eat/start", {o_state, o_score}, {3'd4, 16'h0000});

    // Fail beats success in the same cycle; a lone success wins.
    do_restart();
    do_start();
    i_fail = 2'b01; i_success = 2'b01;
    step();
    i_fail = '0; i_success = '0;
    check("fail over success", {o_state, o_lives[1:0], o_respawn, o_success}, {3'd1, 2'd2, 2'b01, 1'b0});
    i_success = 2'b10; step(); i_success = '0;
    check("success -> WON", {o_state, o_success}, {3'd5, 1'b1});
    do_restart();
    check("restart clears WON", {o_state, o_success}, {3'd0, 1'b0});

    // Score saturation.
    do_start();
    i_eat = 2'b01;
    for (int i = 0; i < 257; i++) step();
    i_eat = '0;
    check("score saturates", o_score, 16'h00FF);

    rst = 1'b1; step(); rst = 1'b0;
    check("rst clears level", {o_level, o_state}, 0);

    // Randomized pulses against the model (no vsync, so no ticks).
    model_restart();
    m_level = 0;
    for (int c = 0; c < 600; c++) begin
      logic r_restart, r_start, r_pause, r_up, r_dn, up;
      logic [N-1:0] r_fail, r_succ, r_eat, f, s, e;
      bit play;
      r_restart = ($urandom_range(0, 24) == 0);
      r_start   = ($urandom_range(0, 3) == 0);
      r_pause   = ($urandom_range(0, 15) == 0);
      r_up      = ($urandom_range(0, 9) == 0);
      r_dn      = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < N; p++) begin
        r_fail[p] = ($urandom_range(0, 7) == 0);
        r_succ[p] = ($urandom_range(0, 59) == 0);
        r_eat[p]  = ($urandom_range(0, 1) == 0);
      end
      i_restart = r_restart; i_start = r_start; i_pause = r_pause;
      i_speed_up = r_up; i_speed_down = r_dn; i_fail = r_fail; i_success = r_succ; i_eat = r_eat;
      step();

      if (r_restart) begin
        model_restart();
      end else begin
        play = (m_state == 1);
        for (int p = 0; p < N; p++) begin
          f[p] = r_fail[p] && play && m_alive[p];
          s[p] = r_succ[p] && play && m_alive[p] && !f[p];
          e[p] = r_eat[p] && play && m_alive[p];
        end
        m_resp = '0;
        for (int p = 0; p < N; p++) begin
          if (f[p]) begin
            if (m_lives[p] > 0) begin m_lives[p]--; m_resp[p] = 1'b1; end
            else m_alive[p] = 0;
          end
          if (e[p]) begin
            if (m_score[p] < 255) m_score[p]++;
            m_eats++;
          end
        end
        up = r_up;
        if (m_eats >= 5) begin m_eats -= 5; up = 1'b1; end
        if (up && !r_dn && m_level < 7) m_level++;
        else if (r_dn && !up && m_level > 0) m_level--;
        if (m_state == 0 && r_start) m_state = 1;
        else if (m_state == 1 && r_pause) m_state = 3;
        else if (m_state == 3 && r_pause) m_state = 1;
        if (play && !m_alive[0] && !m_alive[1]) begin m_state = 4; m_fail_flag = 1; end
        if (s != '0) begin m_state = 5; m_succ_flag = 1; end
      end

      check($sformatf("rnd %0d state", c), o_state, m_state);
      check($sformatf("rnd %0d alive", c), o_alive, {m_alive[1], m_alive[0]});
      check($sformatf("rnd %0d lives", c), o_lives, {2'(m_lives[1]), 2'(m_lives[0])});
      check($sformatf("rnd %0d score", c), o_score, {8'(m_score[1]), 8'(m_score[0])});
      check($sformatf("rnd %0d level", c), o_level, m_level);
      check($sformatf("rnd %0d respawn", c), o_respawn, m_resp);
      check($sformatf("rnd %0d outcome", c), {o_failure, o_success}, {m_fail_flag, m_succ_flag});
    end
    i_restart = 0; i_start = 0; i_pause = 0; i_speed_up = 0; i_speed_down = 0;
    i_fail = '0; i_success = '0; i_eat = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
